ripple_rate_meter: RTL
======================

Name: ripple_rate_meter

Overview:
- Downstream consumer of the 12-bit ripple event counter. It samples the counter's raw q outputs, which settle asynchronously, into the system clock domain.
- Every gate window it reports the number of events counted in that window, using a valid/ready handshake.
- It provides the metastability/ripple-settling guard that the free-running counter lacks, plus wrap-around-safe delta arithmetic.

Parameters:
- WIDTH, 12, width of counter input and rate output
- GATE_CYCLES, 1000, clk cycles in the GATE state per measurement window (≥2)
- STABLE_N, 2, consecutive equal synchronized samples required to accept a counter value (≥1)
- SETTLE_MAX, 15, max clk cycles to wait for a stable sample before forcing capture

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- cnt_in  input  WIDTH  raw q from ripple counter (asynchronous to clk)
- enable  input  1  1 = measure, 0 = idle
- clear_flags  input  1  synchronous clear of sticky flags
- rate  output  WIDTH  events counted in last window, modulo 2^WIDTH
- rate_valid  output  1  rate holds an unconsumed result
- rate_ready  input  1  consumer accepts rate when rate_valid=1
- unstable  output  1  sticky: a capture was forced by settle timeout
- overrun  output  1  sticky: a result was dropped because the previous one was not accepted

Behaviour:
- Reset (reset=0): takes effect immediately.
  - FSM goes to IDLE.
  - All sync/baseline/timer registers are cleared.
  - rate=0, rate_valid=0, unstable=0, overrun=0.
  - Operation resumes on the first clk edge after reset=1.
- Synchronizer: two flops per bit on cnt_in, giving sync_q with 2-cycle latency. sync_prev is sync_q delayed by 1 cycle.
- Stability counter:
  - Increments (saturating) when sync_q==sync_prev; otherwise it is 0.
  - "settled" = counter ≥ STABLE_N.
- Settle timer: counts cycles spent in either SETTLE state. "timeout" = timer reaches SETTLE_MAX.
- FSM states: IDLE, SETTLE_BASE, GATE, SETTLE_END.
  - IDLE: when enable=1, go to SETTLE_BASE. Nothing is emitted.
  - SETTLE_BASE:
    - On settled: baseline<=sync_q, gate timer<=0, go to GATE.
    - On timeout without settled: same action, and set unstable.
  - GATE: gate timer counts 0..GATE_CYCLES-1; on terminal count go to SETTLE_END.
  - SETTLE_END:
    - On settled or timeout: result=(sync_q-baseline) mod 2^WIDTH, baseline<=sync_q, emit result, go to GATE with timer=0.
    - Timeout also sets unstable.
  - enable=0 in any non-IDLE state: go to IDLE next edge, discarding any in-flight window. A pending rate/rate_valid is retained until accepted.
- Window: from baseline capture to end capture, i.e. GATE_CYCLES plus the settle cycles. Consecutive windows abut with no lost events. More than 2^WIDTH-1 events per window aliases; this is a documented limit, not detected.
- Emit is registered: rate/rate_valid update on the edge on which SETTLE_END captures.
- Handshake:
  - Transfer occurs on an edge with rate_valid=1 and rate_ready=1.
  - rate is stable while rate_valid=1.
  - Emit with rate_valid=0, or with a same-cycle transfer: load rate, rate_valid=1, no overrun.
  - Emit with rate_valid=1 and rate_ready=0: new result dropped, rate unchanged, overrun<=1.
  - Transfer without emit: rate_valid<=0, rate holds its last value.
- Sticky flags: cleared by clear_flags=1. If set and clear occur on the same edge, set wins.

Test Plan:
- Reset: GATE_CYCLES=100; assert reset=0 mid-GATE with rate_valid=1 → rate=0, rate_valid=0, unstable=0, overrun=0 before the next clk edge. Release reset → FSM idle until enable.
- Basic count: cnt_in=0x010 held through baseline; change to 0x05A mid-GATE and hold; rate_ready=0 → rate=0x04A, rate_valid=1 held for 50 cycles, unchanged. Then rate_ready=1 → rate_valid=0 next edge.
- Wrap-around: baseline 0xFF0, end value 0x010 → rate=0x020. Next window with cnt_in unchanged → rate=0x000 with rate_valid=1.
- Ripple glitch: cnt_in toggles every clk for 20 cycles spanning SETTLE_END entry → capture forced on the 15th settle cycle, unstable=1, one result emitted. clear_flags=1 → unstable=0.
- Overrun: rate_ready=0 across two windows (deltas 0x005, 0x007) → rate=0x005, overrun=1. Then a window ending with rate_ready=1 on the emit edge → rate=new value, rate_valid=1, overrun still 1 (sticky).
- Enable drop: enable=0 mid-GATE → IDLE, no emit, pending rate retained. Re-enable → new baseline captured; first result covers only post-baseline events.

Source files
------------

// File: rtl/ripple_rate_meter.sv
// ============================================================================
// ripple_rate_meter : synchronises a free-running ripple counter, measures
//                     events per gate window, delivers them on valid/ready
// Revision: 1.0
// ============================================================================
`default_nettype none

module ripple_rate_meter #(
    parameter int WIDTH       = 12,
    parameter int GATE_CYCLES = 1000,
    parameter int STABLE_N    = 2,
    parameter int SETTLE_MAX  = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] cnt_in,
    input  logic             enable,
    input  logic             clear_flags,
    output logic [WIDTH-1:0] rate,
    output logic             rate_valid,
    input  logic             rate_ready,
    output logic             unstable,
    output logic             overrun
);

    localparam int c_GATE_W   = $clog2(GATE_CYCLES);
    localparam int c_SETTLE_W = $clog2(SETTLE_MAX + 1);
    localparam int c_STAB_W   = $clog2(STABLE_N + 1);

    typedef enum logic [1:0] {
        S_IDLE        = 2'd0,
        S_SETTLE_BASE = 2'd1,
        S_GATE        = 2'd2,
        S_SETTLE_END  = 2'd3
    } state_t;

    state_t                  state_q;
    logic [WIDTH-1:0]        sync1_q;
    logic [WIDTH-1:0]        sync_q;
    logic [WIDTH-1:0]        sync_prev_q;
    logic [c_STAB_W-1:0]     stab_q;
    logic [c_STAB_W-1:0]     stab_d;
    logic [c_SETTLE_W-1:0]   settle_tmr_q;
    logic [c_GATE_W-1:0]     gate_tmr_q;
    logic [WIDTH-1:0]        base_q;
    logic [WIDTH-1:0]        rate_q;
    logic                    valid_q;
    logic                    unstable_q;
    logic                    overrun_q;

    logic                    w_in_settle;
    logic                    w_settled;
    logic                    w_timeout;
    logic                    w_capture;
    logic                    w_emit;
    logic                    w_load;
    logic                    w_set_unstable;
    logic                    w_set_overrun;
    logic                    w_gate_done;
    logic [WIDTH-1:0]        w_delta;

    // The stability count tracks the pair that will be visible as
    // sync_q/sync_prev_q after this edge, so "settled" always vouches for
    // the exact value that gets captured.
    always_comb begin
        stab_d = '0;
        if (sync1_q == sync_q) begin
            if (stab_q == c_STAB_W'(STABLE_N)) begin
                stab_d = stab_q;
            end else begin
                stab_d = stab_q + 1'b1;
            end
        end
    end

    assign w_in_settle    = (state_q == S_SETTLE_BASE) || (state_q == S_SETTLE_END);
    assign w_settled      = (stab_q >= c_STAB_W'(STABLE_N));
    assign w_timeout      = (settle_tmr_q >= c_SETTLE_W'(SETTLE_MAX - 1));
    assign w_capture      = w_in_settle && enable && (w_settled || w_timeout);
    assign w_emit         = w_capture && (state_q == S_SETTLE_END);
    assign w_load         = w_emit && (!valid_q || rate_ready);
    assign w_set_unstable = w_capture && !w_settled;
    assign w_set_overrun  = w_emit && valid_q && !rate_ready;
    assign w_gate_done    = (gate_tmr_q == c_GATE_W'(GATE_CYCLES - 1));
    assign w_delta        = sync_q - base_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q     <= '0;
            sync_q      <= '0;
            sync_prev_q <= '0;
            stab_q      <= '0;
        end else begin
            sync1_q     <= cnt_in;
            sync_q      <= sync1_q;
            sync_prev_q <= sync_q;
            stab_q      <= stab_d;
        end
    end

    // Settle timer only runs inside a settle state; saturates so a long
    // stay (enable glitch races) can never wrap back to "not timed out".
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            settle_tmr_q <= '0;
        end else if (w_in_settle) begin
            if (settle_tmr_q != c_SETTLE_W'(SETTLE_MAX)) begin
                settle_tmr_q <= settle_tmr_q + 1'b1;
            end
        end else begin
            settle_tmr_q <= '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            gate_tmr_q <= '0;
            base_q     <= '0;
            rate_q     <= '0;
            valid_q    <= 1'b0;
            unstable_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            if (w_set_unstable) begin
                unstable_q <= 1'b1;
            end else if (clear_flags) begin
                unstable_q <= 1'b0;
            end

            if (w_set_overrun) begin
                overrun_q <= 1'b1;
            end else if (clear_flags) begin
                overrun_q <= 1'b0;
            end

            if (w_load) begin
                rate_q  <= w_delta;
                valid_q <= 1'b1;
            end else if (valid_q && rate_ready) begin
                valid_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (enable) begin
                        state_q <= S_SETTLE_BASE;
                    end
                end
                S_SETTLE_BASE, S_SETTLE_END: begin
                    if (!enable) begin
                        state_q <= S_IDLE;
                    end else if (w_capture) begin
                        base_q     <= sync_q;
                        gate_tmr_q <= '0;
                        state_q    <= S_GATE;
                    end
                end
                S_GATE: begin
                    if (!enable) begin
                        state_q <= S_IDLE;
                    end else if (w_gate_done) begin
                        state_q <= S_SETTLE_END;
                    end else begin
                        gate_tmr_q <= gate_tmr_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign rate       = rate_q;
    assign rate_valid = valid_q;
    assign unstable   = unstable_q;
    assign overrun    = overrun_q;

endmodule

`default_nettype wire
